// File: rtl/ysyx_2022040010_rw_sched_pkg.sv
// Shared constants and types for the rw channel scheduler: requester ids,
// transfer direction, full-width size code, FSM states and the latched command.
package ysyx_2022040010_rw_sched_pkg;

    localparam logic [3:0] RW_ID_ICACHE  = 4'd0;
    localparam logic [3:0] RW_ID_DCACHE  = 4'd1;
    localparam logic [3:0] RW_ID_UNCACHE = 4'd2;

    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam logic [1:0] SIZE_D = 2'b11;

    // Bit positions in the one-hot grant vector
    localparam int GNT_I = 0;
    localparam int GNT_D = 1;
    localparam int GNT_U = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } rw_state_e;

    typedef struct packed {
        logic [3:0]  id;
        logic        req;
        logic [63:0] addr;
        logic [1:0]  size;
        logic [7:0]  mask;
    } rw_cmd_t;

endpackage

// File: rtl/ysyx_2022040010_rw_sched_prio.sv
// Combinational requester select: dcache > uncache > icache, with icache
// promoted to the top when the starve flag is set. Grant is one-hot.
module ysyx_2022040010_rw_prio
    import ysyx_2022040010_rw_sched_pkg::*;
(
    input  logic       icache_req,
    input  logic       dcache_req,
    input  logic       uncache_req,
    input  logic       starve,
    output logic [2:0] grant
);

    always_comb begin
        grant = '0;
        if (icache_req && starve)
            grant[GNT_I] = 1'b1;
        else if (dcache_req)
            grant[GNT_D] = 1'b1;
        else if (uncache_req)
            grant[GNT_U] = 1'b1;
        else if (icache_req)
            grant[GNT_I] = 1'b1;
    end

endmodule

// File: rtl/ysyx_2022040010_rw_sched.sv
// Shares the single AXI rw channel between icache, dcache and uncache: grants
// one requester, holds the latched command until its ready, then pulses refresh.
module ysyx_2022040010_rw_sched
    import ysyx_2022040010_rw_sched_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 64,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_re_i,
    input  logic [ADDR_W-1:0] icache_addr_i,
    output logic [DATA_W-1:0] icache_data_o,
    output logic              icache_refresh_o,
    input  logic              dcache_re_i,
    input  logic              dcache_we_i,
    input  logic [7:0]        dcache_mask_i,
    input  logic [ADDR_W-1:0] dcache_addr_i,
    input  logic [DATA_W-1:0] dcache_olddata_i,
    output logic [DATA_W-1:0] dcache_newdata_o,
    output logic              dcache_refresh_o,
    input  logic              uncache_re_i,
    input  logic              uncache_we_i,
    input  logic [1:0]        uncache_size_i,
    input  logic [7:0]        uncache_mask_i,
    input  logic [ADDR_W-1:0] uncache_addr_i,
    input  logic [DATA_W-1:0] uncache_wdata_i,
    output logic [DATA_W-1:0] uncache_rdata_o,
    output logic              uncache_refresh_o,
    output logic              rw_valid_o,
    input  logic              rw_ready_i,
    output logic              rw_req_o,
    output logic [63:0]       rw_addr_o,
    output logic [1:0]        rw_size_o,
    output logic [3:0]        rw_id_o,
    input  logic [3:0]        rw_id_i,
    input  logic [DATA_W-1:0] data_read_i,
    output logic [DATA_W-1:0] data_write_o,
    output logic [7:0]        w_mask_o,
    output logic              stallreq_for_cache
);

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

    rw_state_e         state, state_nxt;
    rw_cmd_t           cmd, cmd_nxt;
    logic [DATA_W-1:0] wdata, wdata_nxt;
    logic [3:0]        starve_cnt;
    logic [2:0]        grant;
    logic              any_req, granting, capture;

    assign any_req  = icache_re_i | dcache_re_i | dcache_we_i | uncache_re_i | uncache_we_i;
    assign granting = (state == ST_IDLE) && (|grant);
    assign capture  = (state == ST_BUSY) && rw_ready_i && (rw_id_i == cmd.id);

    ysyx_2022040010_rw_prio u_prio (
        .icache_req  (icache_re_i),
        .dcache_req  (dcache_re_i | dcache_we_i),
        .uncache_req (uncache_re_i | uncache_we_i),
        .starve      (starve_cnt == STARVE_MAX),
        .grant       (grant)
    );

    // Command for whichever requester wins this cycle; reads carry no mask/data
    always_comb begin
        cmd_nxt   = '0;
        wdata_nxt = '0;
        if (grant[GNT_D]) begin
            cmd_nxt.id   = RW_ID_DCACHE;
            cmd_nxt.req  = dcache_we_i ? RW_WRITE : RW_READ;
            cmd_nxt.addr = 64'(dcache_addr_i);
            cmd_nxt.size = SIZE_D;
            cmd_nxt.mask = dcache_we_i ? dcache_mask_i : 8'h00;
            wdata_nxt    = dcache_we_i ? dcache_olddata_i : '0;
        end else if (grant[GNT_U]) begin
            cmd_nxt.id   = RW_ID_UNCACHE;
            cmd_nxt.req  = uncache_we_i ? RW_WRITE : RW_READ;
            cmd_nxt.addr = 64'(uncache_addr_i);
            cmd_nxt.size = uncache_size_i;
            cmd_nxt.mask = uncache_we_i ? uncache_mask_i : 8'h00;
            wdata_nxt    = uncache_we_i ? uncache_wdata_i : '0;
        end else if (grant[GNT_I]) begin
            cmd_nxt.id   = RW_ID_ICACHE;
            cmd_nxt.req  = RW_READ;
            cmd_nxt.addr = 64'(icache_addr_i);
            cmd_nxt.size = SIZE_D;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (|grant) state_nxt = ST_BUSY;
            ST_BUSY: if (capture) state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        rw_valid_o        = (state == ST_BUSY);
        icache_refresh_o  = (state == ST_DONE) && (cmd.id == RW_ID_ICACHE);
        dcache_refresh_o  = (state == ST_DONE) && (cmd.id == RW_ID_DCACHE);
        uncache_refresh_o = (state == ST_DONE) && (cmd.id == RW_ID_UNCACHE);
        stallreq_for_cache = (state != ST_IDLE) || any_req;
    end

    // Starve counter only moves when a grant is actually made
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd        <= '0;
            wdata      <= '0;
            starve_cnt <= '0;
        end else if (granting) begin
            cmd   <= cmd_nxt;
            wdata <= wdata_nxt;
            if (grant[GNT_I])
                starve_cnt <= '0;
            else if (icache_re_i && (starve_cnt != STARVE_MAX))
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            icache_data_o    <= '0;
            dcache_newdata_o <= '0;
            uncache_rdata_o  <= '0;
        end else if (capture && (cmd.req == RW_READ)) begin
            case (cmd.id)
                RW_ID_ICACHE:  icache_data_o    <= data_read_i;
                RW_ID_DCACHE:  dcache_newdata_o <= data_read_i;
                RW_ID_UNCACHE: uncache_rdata_o  <= data_read_i;
                default: ;
            endcase
        end
    end

    assign rw_req_o     = cmd.req;
    assign rw_addr_o    = cmd.addr;
    assign rw_size_o    = cmd.size;
    assign rw_id_o      = cmd.id;
    assign w_mask_o     = cmd.mask;
    assign data_write_o = wdata;

endmodule

// File: tb/tb_ysyx_2022040010_rw_sched.sv
// Directed bench for the rw channel scheduler; the bench plays the AXI bridge.
module tb_ysyx_2022040010_rw_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        icache_re_i;
    logic [31:0] icache_addr_i;
    logic [63:0] icache_data_o;
    logic        icache_refresh_o;
    logic        dcache_re_i, dcache_we_i;
    logic [7:0]  dcache_mask_i;
    logic [31:0] dcache_addr_i;
    logic [63:0] dcache_olddata_i, dcache_newdata_o;
    logic        dcache_refresh_o;
    logic        uncache_re_i, uncache_we_i;
    logic [1:0]  uncache_size_i;
    logic [7:0]  uncache_mask_i;
    logic [31:0] uncache_addr_i;
    logic [63:0] uncache_wdata_i, uncache_rdata_o;
    logic        uncache_refresh_o;
    logic        rw_valid_o, rw_ready_i, rw_req_o;
    logic [63:0] rw_addr_o;
    logic [1:0]  rw_size_o;
    logic [3:0]  rw_id_o, rw_id_i;
    logic [63:0] data_read_i, data_write_o;
    logic [7:0]  w_mask_o;
    logic        stallreq_for_cache;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ysyx_2022040010_rw_sched #(.ADDR_W(32), .DATA_W(64), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .icache_re_i(icache_re_i), .icache_addr_i(icache_addr_i),
        .icache_data_o(icache_data_o), .icache_refresh_o(icache_refresh_o),
        .dcache_re_i(dcache_re_i), .dcache_we_i(dcache_we_i), .dcache_mask_i(dcache_mask_i),
        .dcache_addr_i(dcache_addr_i), .dcache_olddata_i(dcache_olddata_i),
        .dcache_newdata_o(dcache_newdata_o), .dcache_refresh_o(dcache_refresh_o),
        .uncache_re_i(uncache_re_i), .uncache_we_i(uncache_we_i), .uncache_size_i(uncache_size_i),
        .uncache_mask_i(uncache_mask_i), .uncache_addr_i(uncache_addr_i),
        .uncache_wdata_i(uncache_wdata_i), .uncache_rdata_o(uncache_rdata_o),
        .uncache_refresh_o(uncache_refresh_o),
        .rw_valid_o(rw_valid_o), .rw_ready_i(rw_ready_i), .rw_req_o(rw_req_o),
        .rw_addr_o(rw_addr_o), .rw_size_o(rw_size_o), .rw_id_o(rw_id_o), .rw_id_i(rw_id_i),
        .data_read_i(data_read_i), .data_write_o(data_write_o), .w_mask_o(w_mask_o),
        .stallreq_for_cache(stallreq_for_cache)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance negedges until rw_valid_o rises; a timeout counts as a failure
    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!rw_valid_o && k < 20);
        chk({tag, "_valid_seen"}, 64'(rw_valid_o), 64'd1);
    endtask

    // Bridge answers for one cycle; returns at the negedge of the DONE cycle
    task automatic complete(input logic [3:0] id, input logic [63:0] d);
        rw_ready_i  = 1'b1;
        rw_id_i     = id;
        data_read_i = d;
        @(negedge clk);
        rw_ready_i  = 1'b0;
        data_read_i = '0;
    endtask

    initial begin
        rst = 1'b1;
        icache_re_i = 0; icache_addr_i = '0;
        dcache_re_i = 0; dcache_we_i = 0; dcache_mask_i = '0; dcache_addr_i = '0; dcache_olddata_i = '0;
        uncache_re_i = 0; uncache_we_i = 0; uncache_size_i = '0; uncache_mask_i = '0;
        uncache_addr_i = '0; uncache_wdata_i = '0;
        rw_ready_i = 0; rw_id_i = '0; data_read_i = '0;
        repeat (3) @(negedge clk);

        // reset state
        chk("rst_valid", 64'(rw_valid_o), 64'd0);
        chk("rst_refresh", {61'd0, icache_refresh_o, dcache_refresh_o, uncache_refresh_o}, 64'd0);
        chk("rst_addr", rw_addr_o, 64'd0);
        chk("rst_idata", icache_data_o, 64'd0);
        chk("rst_stall", 64'(stallreq_for_cache), 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // single icache read, bridge answers after 5 valid cycles
        icache_re_i = 1; icache_addr_i = 32'h8000_0000;
        #1 chk("t1_stall_comb", 64'(stallreq_for_cache), 64'd1);
        wait_valid("t1");
        chk("t1_addr", rw_addr_o, 64'h0000_0000_8000_0000);
        chk("t1_id_req_size", {56'd0, rw_id_o, rw_req_o, rw_size_o}, {56'd0, 4'd0, 1'b0, 2'b11});
        for (int k = 2; k <= 5; k++) begin
            @(negedge clk);
            chk("t1_valid_hold", 64'(rw_valid_o), 64'd1);
        end
        complete(4'd0, 64'h1122_3344_5566_7788);
        chk("t1_refresh", 64'(icache_refresh_o), 64'd1);
        chk("t1_valid_drop", 64'(rw_valid_o), 64'd0);
        chk("t1_idata", icache_data_o, 64'h1122_3344_5566_7788);
        icache_re_i = 0;
        @(negedge clk);
        chk("t1_refresh_once", 64'(icache_refresh_o), 64'd0);

        // three simultaneous requests: dcache, uncache, icache in that order
        icache_re_i = 1; icache_addr_i = 32'h8000_0100;
        dcache_re_i = 1; dcache_addr_i = 32'h8000_2000;
        uncache_we_i = 1; uncache_addr_i = 32'h1000_0004; uncache_size_i = 2'd2;
        uncache_mask_i = 8'hF0; uncache_wdata_i = 64'hCAFE_0000_0000_0000;
        wait_valid("t2a");
        chk("t2a_id_req", {59'd0, rw_id_o, rw_req_o}, {59'd0, 4'd1, 1'b0});
        chk("t2a_addr", rw_addr_o, 64'h8000_2000);
        chk("t2a_mask", 64'(w_mask_o), 64'h00);
        complete(4'd1, 64'hA5A5_0000_0000_0001);
        chk("t2a_refresh", {61'd0, icache_refresh_o, dcache_refresh_o, uncache_refresh_o}, 64'b010);
        chk("t2a_ddata", dcache_newdata_o, 64'hA5A5_0000_0000_0001);
        dcache_re_i = 0;
        wait_valid("t2b");
        chk("t2b_id_req", {59'd0, rw_id_o, rw_req_o}, {59'd0, 4'd2, 1'b1});
        chk("t2b_size_mask", {54'd0, rw_size_o, w_mask_o}, {54'd0, 2'd2, 8'hF0});
        chk("t2b_wdata", data_write_o, 64'hCAFE_0000_0000_0000);
        complete(4'd2, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("t2b_refresh", {61'd0, icache_refresh_o, dcache_refresh_o, uncache_refresh_o}, 64'b001);
        chk("t2b_urdata_kept", uncache_rdata_o, 64'd0);
        uncache_we_i = 0;
        wait_valid("t2c");
        chk("t2c_id_req", {59'd0, rw_id_o, rw_req_o}, {59'd0, 4'd0, 1'b0});
        complete(4'd0, 64'h0BAD_F00D_0000_0002);
        chk("t2c_refresh", {61'd0, icache_refresh_o, dcache_refresh_o, uncache_refresh_o}, 64'b100);
        icache_re_i = 0;

        // dcache write: command carries mask/data, read register untouched
        dcache_we_i = 1; dcache_mask_i = 8'h0F; dcache_addr_i = 32'h8000_3000;
        dcache_olddata_i = 64'hDEAD;
        wait_valid("t3");
        chk("t3_req", 64'(rw_req_o), 64'd1);
        chk("t3_mask", 64'(w_mask_o), 64'h0F);
        chk("t3_wdata", data_write_o, 64'hDEAD);
        complete(4'd1, 64'h1234_5678_9ABC_DEF0);
        chk("t3_refresh", 64'(dcache_refresh_o), 64'd1);
        chk("t3_ddata_kept", dcache_newdata_o, 64'hA5A5_0000_0000_0001);
        dcache_we_i = 0;

        // starvation: four dcache wins, then icache on the fifth arbitration
        icache_re_i = 1; dcache_re_i = 1;
        for (int k = 1; k <= 4; k++) begin
            wait_valid("t4_d");
            chk("t4_dcache_wins", 64'(rw_id_o), 64'd1);
            complete(4'd1, 64'(k));
        end
        wait_valid("t4_i");
        chk("t4_icache_promoted", 64'(rw_id_o), 64'd0);
        complete(4'd0, 64'h5555);
        chk("t4_irefresh", 64'(icache_refresh_o), 64'd1);
        icache_re_i = 0; dcache_re_i = 0;

        // ready carrying the wrong id is ignored
        dcache_re_i = 1; dcache_addr_i = 32'h8000_4000;
        wait_valid("t5");
        rw_ready_i = 1; rw_id_i = 4'd2; data_read_i = 64'hBBBB;
        @(negedge clk);
        rw_ready_i = 0;
        chk("t5_still_busy", 64'(rw_valid_o), 64'd1);
        chk("t5_no_refresh", {61'd0, icache_refresh_o, dcache_refresh_o, uncache_refresh_o}, 64'b000);
        @(negedge clk);
        complete(4'd1, 64'h7777_8888);
        chk("t5_refresh", 64'(dcache_refresh_o), 64'd1);
        chk("t5_ddata", dcache_newdata_o, 64'h7777_8888);
        dcache_re_i = 0;

        // reset while busy aborts with no pulse, then a fresh request works
        uncache_re_i = 1; uncache_addr_i = 32'h1000_0000; uncache_size_i = 2'd0;
        wait_valid("t6");
        rst = 1; uncache_re_i = 0;
        @(negedge clk);
        chk("t6_valid_abort", 64'(rw_valid_o), 64'd0);
        chk("t6_no_refresh", {61'd0, icache_refresh_o, dcache_refresh_o, uncache_refresh_o}, 64'b000);
        chk("t6_ddata_reset", dcache_newdata_o, 64'd0);
        rst = 0;
        @(negedge clk);
        chk("t6_no_late_refresh", 64'(uncache_refresh_o), 64'd0);
        uncache_re_i = 1; uncache_addr_i = 32'h1000_0008; uncache_size_i = 2'd1;
        wait_valid("t6b");
        chk("t6b_size", 64'(rw_size_o), 64'd1);
        complete(4'd2, 64'h0000_0000_0000_ABCD);
        chk("t6b_refresh", 64'(uncache_refresh_o), 64'd1);
        chk("t6b_urdata", uncache_rdata_o, 64'hABCD);
        uncache_re_i = 0;
        @(negedge clk);
        chk("t6b_idle_stall", 64'(stallreq_for_cache), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
